rsa4k: RTL and testbench
========================

Name: rsa4k

Overview:
- Iterative modular exponentiation engine: cypher = message^exponent mod modulus, WIDTH-bit operands (default 4096).
- Uses radix-2 bit-serial Montgomery multiplication with on-chip R^2 mod N precomputation.
- Left-to-right square-and-multiply.
- RSA encrypt/decrypt primitive; sits behind a controller that loads operands and waits on done.

Parameters:
- WIDTH, 4096: operand width in bits (message, exponent, modulus, cypher). Montgomery R = 2^WIDTH.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- go  input  1  level start request.
- message  input  WIDTH  base M; any value < 2^WIDTH accepted.
- exponent  input  WIDTH  exponent E.
- modulus  input  WIDTH  modulus N; must be odd and >= 3 for a defined result.
- cypher  output  WIDTH  result M^E mod N, registered.
- done  output  1  result valid.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Under reset: state=IDLE, done=0, cypher=0, all datapath registers cleared.
- Reset mid-operation aborts immediately, with the same values as above.
- IDLE: done=0. If go=1, capture message/exponent/modulus into internal registers on that edge, then go to PRE. Inputs are ignored after capture.
- PRE: r starts at 1. For exactly 2*WIDTH cycles: r = 2r; if r >= N then r = r - N. Result R2 = 2^(2W) mod N. r is WIDTH+1 bits wide.
- MonPro(A,B), exactly WIDTH+1 cycles:
  - Start with t = 0.
  - For i = 0..WIDTH-1: t = t + a_i*B; if t is odd, t = t + N; t = t >> 1.
  - Final cycle: if t >= N, t = t - N.
  - t is WIDTH+2 bits wide. Result is always < N for A*B < N*R.
- Sequence:
  1. Mbar = MonPro(M, R2). Handles M >= N implicitly.
  2. X = MonPro(1, R2).
  3. Scan E from bit WIDTH-1 down to bit 0. For each bit: X = MonPro(X, X); if the bit is 1, X = MonPro(X, Mbar).
  4. cypher = MonPro(X, 1).
- States: IDLE -> PRE -> TOMONT_M -> TOMONT_1 -> SQUARE <-> MULTIPLY -> FROMMONT -> DONE.
- DONE: cypher is loaded and done=1 on the same edge. done and cypher are held while go=1. When go=0, go to IDLE: done drops, cypher is held.
- One operation per go assertion. go held high after done does not restart; a new run needs go low, then high.
- Latency without the option, from the capture edge to done high:
  - 2W + (W+1)*(3 + W + popcount(E)) + 2 cycles.
  - Worst case at W=4096 is about 33.6M cycles.
- Boundary cases:
  - E = 0 -> cypher = 1 (N >= 3).
  - M = 0, E > 0 -> cypher = 0.
  - M >= N -> result equals (M mod N)^E mod N.
  - N even, or N < 3 -> cypher value is undefined, but done must still assert with the same latency.

Optional Feature:
- Macro: RSA4K_SKIP_ZEROS_EN.
- Defined: after FROMMONT-independent setup, scanning starts at the most significant set bit of E; leading zero bits consume no MonPro. Bit location is done by a shift search of 1 cycle per skipped bit. If E = 0, go straight to FROMMONT. Result is identical; latency is lower.
- Undefined: all WIDTH exponent bits are scanned. The latency formula above applies exactly.

Decomposition:
- Package rsa4k_pkg: default WIDTH constant; state enum (IDLE, PRE, TOMONT_M, TOMONT_1, SQUARE, MULTIPLY, FROMMONT, DONE).
- Sub-module mont_mul: bit-serial Montgomery multiplier.
  - Parameter WIDTH.
  - Ports: clk, reset, start, a, b, n, result, ready.
  - ready pulses after exactly WIDTH+1 cycles.
- rsa4k holds the controller FSM, the PRE doubling loop and the operand registers.

Test Plan:
- W=4096: M=0x32, E=37, N=77, go held -> done asserts once; cypher=8; done stays 1 while go=1.
- M=8, E=13, N=77 -> cypher=50 (0x32). Then drop go -> done=0. Re-raise go with M=50, E=37 -> cypher=8.
- E=0, M=5, N=77 -> cypher=1. Also E=1, M=100, N=77 -> cypher=23 (M >= N case).
- Full 4096-bit odd N, random M < N, E=65537 -> cypher matches a software bignum model. Measured latency equals the formula.
- Assert reset for 1 cycle mid-SQUARE -> next edge done=0, cypher=0, state IDLE. A fresh go then yields a correct result.
- With RSA4K_SKIP_ZEROS_EN: same vectors give the same cyphers. Latency for E=37 is less than the full-scan value.

Source files
------------

// File: rtl/rsa4k_pkg.sv
`default_nettype none
// ============================================================================
// Module : rsa4k_pkg
// Shared width default and controller state encoding for the rsa4k engine.
// Rev    : 1.0  initial release
// ============================================================================
package rsa4k_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4096;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PRE      = 3'd1,
      TOMONT_M = 3'd2,
      TOMONT_1 = 3'd3,
      SQUARE   = 3'd4,
      MULTIPLY = 3'd5,
      FROMMONT = 3'd6,
      DONE     = 3'd7
   } state_t;

endpackage
`default_nettype wire

// File: rtl/rsa4k_mont_mul.sv
`default_nettype none
// ============================================================================
// Module : mont_mul
// Radix-2 bit-serial Montgomery multiplier: result = a*b*2^-WIDTH mod n.
// Rev    : 1.0  initial release
// ============================================================================
module mont_mul
   import rsa4k_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] n,
   output logic [WIDTH-1:0] result,
   output logic             ready
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] n_q;
   logic [WIDTH+1:0] t_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic [WIDTH-1:0] result_q;
   logic             ready_q;

   logic             w_abit;
   logic [WIDTH-1:0] w_bsel;
   logic [WIDTH-1:0] w_nsrc;
   logic [WIDTH+1:0] w_t_in;
   logic [WIDTH+1:0] w_s1;
   logic [WIDTH+1:0] w_s2;
   logic [WIDTH+1:0] w_diff;
   logic             w_borrow;

   // The start cycle already performs iteration 0 straight from the inputs,
   // so a whole product fits in WIDTH+1 cycles including the final reduction.
   assign w_t_in = start ? '0 : t_q;
   assign w_abit = start ? a[0] : a_q[0];
   assign w_bsel = w_abit ? (start ? b : b_q) : '0;
   assign w_nsrc = start ? n : n_q;
   assign w_s1   = w_t_in + {2'b00, w_bsel};
   assign w_s2   = w_s1 + (w_s1[0] ? {2'b00, w_nsrc} : '0);

   assign {w_borrow, w_diff} = {1'b0, t_q} - {3'b000, n_q};

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q      <= '0;
         b_q      <= '0;
         n_q      <= '0;
         t_q      <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         if (start) begin
            a_q    <= a >> 1;
            b_q    <= b;
            n_q    <= n;
            t_q    <= w_s2 >> 1;
            cnt_q  <= CW'(1);
            busy_q <= 1'b1;
         end else if (busy_q) begin
            if (cnt_q == CW'(WIDTH)) begin
               result_q <= WIDTH'(w_borrow ? t_q : w_diff);
               ready_q  <= 1'b1;
               busy_q   <= 1'b0;
            end else begin
               t_q   <= w_s2 >> 1;
               a_q   <= a_q >> 1;
               cnt_q <= cnt_q + CW'(1);
            end
         end
      end
   end

   assign result = result_q;
   assign ready  = ready_q;

endmodule
`default_nettype wire

// File: rtl/rsa4k.sv
`default_nettype none
// ============================================================================
// Module : rsa4k
// Modular exponentiation cypher = message^exponent mod modulus (Montgomery,
// left-to-right square-and-multiply). Option: RSA4K_SKIP_ZEROS_EN.
// Rev    : 1.0  initial release
// ============================================================================
module rsa4k
   import rsa4k_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [WIDTH-1:0] message,
   input  logic [WIDTH-1:0] exponent,
   input  logic [WIDTH-1:0] modulus,
   output logic [WIDTH-1:0] cypher,
   output logic             done
);

   localparam int unsigned      CW    = $clog2(2 * WIDTH + 1);
   localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

   state_t           state_q;
   logic [WIDTH-1:0] msg_q;
   logic [WIDTH-1:0] exp_q;
   logic [WIDTH-1:0] n_q;
   logic [WIDTH:0]   r_q;
   logic [WIDTH-1:0] mbar_q;
   logic [CW-1:0]    cnt_q;
   logic             kick_q;
   logic [WIDTH-1:0] cypher_q;
   logic             done_q;
`ifdef RSA4K_SKIP_ZEROS_EN
   logic             seek_q;
`endif

   logic             w_start;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_result;
   logic             w_ready;
   logic [WIDTH:0]   w_dbl;
   logic [WIDTH:0]   w_rdiff;
   logic             w_rborrow;
   logic             w_bit;
   logic             w_last;

   assign w_dbl                = r_q << 1;
   assign {w_rborrow, w_rdiff} = {1'b0, w_dbl} - {2'b00, n_q};
   assign w_bit                = exp_q[WIDTH-1];
   assign w_last               = (cnt_q == '0);

   // X is never stored separately: it is always the multiplier's last result,
   // so the next product is launched on the same edge the previous one lands.
   always_comb begin
      w_start = 1'b0;
      w_a     = w_result;
      w_b     = w_result;
      case (state_q)
         TOMONT_M: begin
            if (kick_q) begin
               w_start = 1'b1;
               w_a     = msg_q;
               w_b     = r_q[WIDTH-1:0];
            end else if (w_ready) begin
               w_start = 1'b1;
               w_a     = c_ONE;
               w_b     = r_q[WIDTH-1:0];
            end
         end
         TOMONT_1: begin
            if (w_ready) begin
`ifdef RSA4K_SKIP_ZEROS_EN
               if (exp_q == '0) begin
                  w_start = 1'b1;
                  w_b     = c_ONE;
               end
`else
               w_start = 1'b1;
`endif
            end
         end
         SQUARE: begin
`ifdef RSA4K_SKIP_ZEROS_EN
            if (seek_q) begin
               if (w_bit) begin
                  w_start = 1'b1;
               end else if (w_last) begin
                  w_start = 1'b1;
                  w_b     = c_ONE;
               end
            end else
`endif
            if (w_ready) begin
               w_start = 1'b1;
               if (w_bit)       w_b = mbar_q;
               else if (w_last) w_b = c_ONE;
            end
         end
         MULTIPLY: begin
            if (w_ready) begin
               w_start = 1'b1;
               if (w_last) w_b = c_ONE;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         msg_q    <= '0;
         exp_q    <= '0;
         n_q      <= '0;
         r_q      <= '0;
         mbar_q   <= '0;
         cnt_q    <= '0;
         kick_q   <= 1'b0;
         cypher_q <= '0;
         done_q   <= 1'b0;
`ifdef RSA4K_SKIP_ZEROS_EN
         seek_q   <= 1'b0;
`endif
      end else begin
         kick_q <= 1'b0;
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (go) begin
                  msg_q   <= message;
                  exp_q   <= exponent;
                  n_q     <= modulus;
                  r_q     <= {{WIDTH{1'b0}}, 1'b1};
                  cnt_q   <= '0;
                  state_q <= PRE;
               end
            end
            PRE: begin
               // 2*WIDTH doublings of 1 leave R^2 mod N in r.
               if (cnt_q == CW'(2 * WIDTH)) begin
                  state_q <= TOMONT_M;
                  kick_q  <= 1'b1;
               end else begin
                  r_q   <= w_rborrow ? w_dbl : w_rdiff;
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            TOMONT_M: begin
               if (w_ready) begin
                  mbar_q  <= w_result;
                  state_q <= TOMONT_1;
               end
            end
            TOMONT_1: begin
               if (w_ready) begin
                  cnt_q <= CW'(WIDTH - 1);
`ifdef RSA4K_SKIP_ZEROS_EN
                  if (exp_q == '0) begin
                     state_q <= FROMMONT;
                  end else begin
                     state_q <= SQUARE;
                     seek_q  <= 1'b1;
                  end
`else
                  state_q <= SQUARE;
`endif
               end
            end
            SQUARE: begin
`ifdef RSA4K_SKIP_ZEROS_EN
               if (seek_q) begin
                  if (w_bit) begin
                     seek_q <= 1'b0;
                  end else if (w_last) begin
                     seek_q  <= 1'b0;
                     state_q <= FROMMONT;
                  end else begin
                     exp_q <= exp_q << 1;
                     cnt_q <= cnt_q - CW'(1);
                  end
               end else
`endif
               if (w_ready) begin
                  if (w_bit) begin
                     state_q <= MULTIPLY;
                  end else if (w_last) begin
                     state_q <= FROMMONT;
                  end else begin
                     exp_q <= exp_q << 1;
                     cnt_q <= cnt_q - CW'(1);
                  end
               end
            end
            MULTIPLY: begin
               if (w_ready) begin
                  if (w_last) begin
                     state_q <= FROMMONT;
                  end else begin
                     state_q <= SQUARE;
                     exp_q   <= exp_q << 1;
                     cnt_q   <= cnt_q - CW'(1);
                  end
               end
            end
            FROMMONT: begin
               if (w_ready) begin
                  cypher_q <= w_result;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               if (!go) begin
                  done_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   mont_mul #(
      .WIDTH (WIDTH)
   ) u_mont (
      .clk    (clk),
      .reset  (reset),
      .start  (w_start),
      .a      (w_a),
      .b      (w_b),
      .n      (n_q),
      .result (w_result),
      .ready  (w_ready)
   );

   assign cypher = cypher_q;
   assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rsa4k.sv
`default_nettype none
// ============================================================================
// Module : tb_rsa4k
// Directed and random modexp runs on a reduced-width rsa4k against a plain
// arithmetic square-and-multiply model, plus latency, hold and reset checks.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rsa4k;
   import rsa4k_pkg::*;

   localparam int W      = 32;
   localparam int BUDGET = 2 * W + (W + 1) * (3 + 2 * W) + 20;

   logic         clk;
   logic         reset;
   logic         go;
   logic [W-1:0] message;
   logic [W-1:0] exponent;
   logic [W-1:0] modulus;
   logic [W-1:0] cypher;
   logic         done;

   int total;
   int bad;

   rsa4k #(
      .WIDTH (W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .go       (go),
      .message  (message),
      .exponent (exponent),
      .modulus  (modulus),
      .cypher   (cypher),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Right-to-left binary exponentiation on plain integers.
   function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] m,
                                               input logic [W-1:0] e,
                                               input logic [W-1:0] n);
      logic [2*W-1:0] acc;
      logic [2*W-1:0] base;
      acc  = (2*W)'(1) % (2*W)'(n);
      base = (2*W)'(m) % (2*W)'(n);
      for (int i = 0; i < W; i++) begin
         if (e[i]) acc = (acc * base) % (2*W)'(n);
         base = (base * base) % (2*W)'(n);
      end
      return acc[W-1:0];
   endfunction

   function automatic int full_latency(input logic [W-1:0] e);
      return 2 * W + (W + 1) * (3 + W + $countones(e)) + 2;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Launch one operation, scramble inputs after capture, wait for done.
   task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] e,
                         input logic [W-1:0] n, output int lat);
      @(negedge clk);
      message  = m;
      exponent = e;
      modulus  = n;
      go       = 1'b1;
      @(posedge clk);
      #1;
      message  = $urandom;
      exponent = $urandom;
      modulus  = $urandom;
      lat = 0;
      while (done !== 1'b1 && lat < BUDGET) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("done_timeout", {63'b0, done}, 64'd1);
   endtask

   task automatic drop_go();
      @(negedge clk);
      go = 1'b0;
      @(posedge clk);
      #1;
      check("done_drop", {63'b0, done}, 64'd0);
   endtask

   task automatic vector(input string tag, input logic [W-1:0] m,
                         input logic [W-1:0] e, input logic [W-1:0] n);
      int lat;
      logic [W-1:0] expc;
      expc = ref_modexp(m, e, n);
      run_op(m, e, n, lat);
      check(tag, 64'(cypher), 64'(expc));
`ifndef RSA4K_SKIP_ZEROS_EN
      check({tag, "_lat"}, 64'(lat), 64'(full_latency(e)));
`endif
      drop_go();
      check({tag, "_held"}, 64'(cypher), 64'(expc));
   endtask

   initial begin
      int           lat;
      bit           ok;
      logic [W-1:0] m;
      logic [W-1:0] e;
      logic [W-1:0] n;
      logic [W-1:0] expc;

      total    = 0;
      bad      = 0;
      reset    = 1'b1;
      go       = 1'b0;
      message  = '0;
      exponent = '0;
      modulus  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_done", {63'b0, done}, 64'd0);
      check("rst_cypher", 64'(cypher), 64'd0);
      check("rst_state", 64'(dut.state_q), 64'(IDLE));
      @(negedge clk);
      reset = 1'b0;

      // Basic vector with go held: done stays, no restart.
      run_op(W'(32'h32), W'(37), W'(77), lat);
      check("e37_cypher", 64'(cypher), 64'd8);
`ifdef RSA4K_SKIP_ZEROS_EN
      check("e37_lat_lower", {63'b0, lat < full_latency(W'(37))}, 64'd1);
`else
      check("e37_lat", 64'(lat), 64'(full_latency(W'(37))));
`endif
      ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done !== 1'b1 || cypher !== W'(8)) ok = 1'b0;
      end
      check("e37_hold", {63'b0, ok}, 64'd1);
      drop_go();
      check("e37_held", 64'(cypher), 64'd8);

      vector("m8_e13", W'(8), W'(13), W'(77));
      check("m8_e13_const", 64'(cypher), 64'd50);
      vector("m50_e37", W'(50), W'(37), W'(77));
      vector("e0", W'(5), W'(0), W'(77));
      check("e0_const", 64'(cypher), 64'd1);
      vector("m_ge_n", W'(100), W'(1), W'(77));
      check("m_ge_n_const", 64'(cypher), 64'd23);
      vector("m0", W'(0), W'(5), W'(77));

      // Full-width random modulus, public exponent 65537.
      n = W'($urandom) | {1'b1, {(W-2){1'b0}}, 1'b1};
      m = W'($urandom) % n;
      vector("f4", m, W'(65537), n);

      for (int k = 0; k < 3; k++) begin
         n = W'($urandom) | {1'b1, {(W-2){1'b0}}, 1'b1};
         m = W'($urandom);
         e = W'($urandom);
         vector($sformatf("rnd%0d", k), m, e, n);
      end

      // Reset while squaring aborts immediately.
      @(negedge clk);
      message  = W'(50);
      exponent = W'(37);
      modulus  = W'(77);
      go       = 1'b1;
      repeat (200) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      go    = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_done", {63'b0, done}, 64'd0);
      check("midrst_cypher", 64'(cypher), 64'd0);
      check("midrst_state", 64'(dut.state_q), 64'(IDLE));
      @(negedge clk);
      reset = 1'b0;
      vector("after_rst", W'(50), W'(37), W'(77));

      // Even modulus: value undefined, timing must still hold.
      expc = '0;
      run_op(W'(5), W'(37), W'(78), lat);
`ifndef RSA4K_SKIP_ZEROS_EN
      check("even_n_lat", 64'(lat), 64'(full_latency(W'(37))));
`endif
      drop_go();
      check("even_n_state", 64'(dut.state_q), 64'(IDLE));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
